// File: rtl/gestor_puertas.sv
// Request latch and door open/dwell/close sequencer for the 4-floor lift.
// Latency: button to s is 1 cycle; trigger to door motion is 1 cycle; esperar is combinational.
// Backpressure: esperar freezes the movement algorithm while the door is not closed.
module gestor_puertas #(
    parameter int T_ABRIR   = 50,
    parameter int T_ABIERTA = 200,
    parameter int T_CERRAR  = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] botones,
    input  logic [3:0] estado,
    input  logic       sensor_obstaculo,
    input  logic       boton_abrir,
    output logic [9:0] s,
    output logic       esperar,
    output logic [1:0] motor_puerta,
    output logic       puerta_abierta
);

    typedef enum logic [1:0] {CERRADA, ABRIENDO, ABIERTA, CERRANDO} puerta_t;

    localparam logic [15:0] C_ABRIR   = 16'(T_ABRIR - 1);
    localparam logic [15:0] C_ABIERTA = 16'(T_ABIERTA - 1);
    localparam logic [15:0] C_CERRAR  = 16'(T_CERRAR - 1);

    localparam logic [1:0] MOT_OFF   = 2'b00;
    localparam logic [1:0] MOT_ABRIR = 2'b01;
    localparam logic [1:0] MOT_CERR  = 2'b10;

    puerta_t     st;
    logic [15:0] cnt;
    logic [9:0]  mascara;
    logic        abrir_pend;
    logic        reabrir;

    // Requests served at the current floor: cabin call plus the hall call in the travel direction.
    always_comb begin
        mascara = 10'h000;
        case (estado[1:0])
            2'd0:    mascara = 10'h041;
            2'd1:    mascara = estado[2] ? 10'h084 : 10'h082;
            2'd2:    mascara = estado[2] ? 10'h110 : 10'h108;
            default: mascara = 10'h220;
        endcase
    end

    assign abrir_pend = (st == CERRADA) && !estado[3] && ((|(s & mascara)) || boton_abrir);
    assign reabrir    = sensor_obstaculo || boton_abrir || (|(botones & mascara));
    assign esperar    = (st != CERRADA) || abrir_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= 10'h000;
        end else if (abrir_pend) begin
            s <= (s | botones) & ~mascara;
        end else if (st != CERRADA) begin
            s <= s | (botones & ~mascara);
        end else begin
            s <= s | botones;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st             <= CERRADA;
            cnt            <= 16'd0;
            motor_puerta   <= MOT_OFF;
            puerta_abierta <= 1'b0;
        end else begin
            case (st)
                CERRADA: begin
                    if (abrir_pend) begin
                        st           <= ABRIENDO;
                        cnt          <= C_ABRIR;
                        motor_puerta <= MOT_ABRIR;
                    end
                end
                ABRIENDO: begin
                    if (cnt == 16'd0) begin
                        st             <= ABIERTA;
                        cnt            <= C_ABIERTA;
                        motor_puerta   <= MOT_OFF;
                        puerta_abierta <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ABIERTA: begin
                    if (reabrir) begin
                        cnt <= C_ABIERTA;
                    end else if (cnt == 16'd0) begin
                        st             <= CERRANDO;
                        cnt            <= C_CERRAR;
                        motor_puerta   <= MOT_CERR;
                        puerta_abierta <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    // A reopen request beats the end of the closing stroke.
                    if (reabrir) begin
                        st           <= ABRIENDO;
                        cnt          <= C_ABRIR;
                        motor_puerta <= MOT_ABRIR;
                    end else if (cnt == 16'd0) begin
                        st           <= CERRADA;
                        motor_puerta <= MOT_OFF;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gestor_puertas.sv
// Scoreboard bench for gestor_puertas with short door timings (2/4/2).
module tb_gestor_puertas;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] botones = '0;
    logic [3:0] estado = '0;
    logic       sensor_obstaculo = 1'b0;
    logic       boton_abrir = 1'b0;
    logic [9:0] s;
    logic       esperar;
    logic [1:0] motor_puerta;
    logic       puerta_abierta;

    gestor_puertas #(.T_ABRIR(2), .T_ABIERTA(4), .T_CERRAR(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .botones          (botones),
        .estado           (estado),
        .sensor_obstaculo (sensor_obstaculo),
        .boton_abrir      (boton_abrir),
        .s                (s),
        .esperar          (esperar),
        .motor_puerta     (motor_puerta),
        .puerta_abierta   (puerta_abierta)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] s;
        logic [1:0] m;
        logic       p;
        logic       e;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_cyc = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            n_cmp++;
            if (s !== x.s || motor_puerta !== x.m || puerta_abierta !== x.p || esperar !== x.e) begin
                n_bad++;
                $display("FAIL cyc%0d: got s=%h motor=%b abierta=%b esperar=%b, want s=%h motor=%b abierta=%b esperar=%b",
                         x.tag, s, motor_puerta, puerta_abierta, esperar, x.s, x.m, x.p, x.e);
            end
        end
    end

    // One cycle: drive inputs just after the edge, queue what the monitor must see this cycle.
    task automatic cyc(input logic r, input logic [9:0] b, input logic [3:0] e, input logic so,
                       input logic ba, input logic [9:0] xs, input logic [1:0] xm,
                       input logic xp, input logic xe);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n            = r;
        botones          = b;
        estado           = e;
        sensor_obstaculo = so;
        boton_abrir      = ba;
        n_cyc++;
        x.s = xs; x.m = xm; x.p = xp; x.e = xe; x.tag = n_cyc;
        q.push_back(x);
    endtask

    task automatic rep(input int n, input logic [3:0] e, input logic [9:0] xs,
                       input logic [1:0] xm, input logic xp, input logic xe);
        for (int i = 0; i < n; i++) cyc(1'b1, 10'h000, e, 1'b0, 1'b0, xs, xm, xp, xe);
    endtask

    // Undisturbed 2/4/2 sequence following the trigger cycle.
    task automatic puerta(input logic [3:0] e, input logic [9:0] xs);
        rep(2, e, xs, 2'b01, 1'b0, 1'b1);
        rep(4, e, xs, 2'b00, 1'b1, 1'b1);
        rep(2, e, xs, 2'b10, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset state
        cyc(1'b0, 10'h000, 4'b0101, 1'b0, 1'b0, 10'h000, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 10'h000, 4'b0101, 1'b0, 1'b0, 10'h000, 2'b00, 1'b0, 1'b0);

        // Floor 2, cabin call 7: one-cycle pulse, esperar for 9 cycles
        cyc(1'b1, 10'h080, 4'b0101, 1'b0, 1'b0, 10'h000, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 10'h000, 4'b0101, 1'b0, 1'b0, 10'h080, 2'b00, 1'b0, 1'b1);
        puerta(4'b0101, 10'h000);
        rep(2, 4'b0101, 10'h000, 2'b00, 1'b0, 1'b0);

        // Floor 3 going up with both hall calls: only the up call is served
        cyc(1'b1, 10'h018, 4'b0110, 1'b0, 1'b0, 10'h000, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 10'h000, 4'b0110, 1'b0, 1'b0, 10'h018, 2'b00, 1'b0, 1'b1);
        puerta(4'b0110, 10'h008);
        rep(3, 4'b0110, 10'h008, 2'b00, 1'b0, 1'b0);

        // Direction flips to down: call 3 now serviceable; other calls latch mid-sequence; reset in ABIERTA
        cyc(1'b1, 10'h000, 4'b0010, 1'b0, 1'b0, 10'h008, 2'b00, 1'b0, 1'b1);
        rep(2, 4'b0010, 10'h000, 2'b01, 1'b0, 1'b1);
        cyc(1'b1, 10'h200, 4'b0010, 1'b0, 1'b0, 10'h000, 2'b00, 1'b1, 1'b1);
        cyc(1'b1, 10'h000, 4'b0010, 1'b0, 1'b0, 10'h200, 2'b00, 1'b1, 1'b1);
        cyc(1'b0, 10'h000, 4'b0010, 1'b0, 1'b0, 10'h000, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 10'h000, 4'b0010, 1'b0, 1'b0, 10'h000, 2'b00, 1'b0, 1'b0);

        // Floor 2 up hall call; obstruction extends dwell; door button reopens during closing
        cyc(1'b1, 10'h004, 4'b0101, 1'b0, 1'b0, 10'h000, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 10'h000, 4'b0101, 1'b0, 1'b0, 10'h004, 2'b00, 1'b0, 1'b1);
        rep(2, 4'b0101, 10'h000, 2'b01, 1'b0, 1'b1);
        rep(1, 4'b0101, 10'h000, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 10'h000, 4'b0101, 1'b1, 1'b0, 10'h000, 2'b00, 1'b1, 1'b1);
        rep(4, 4'b0101, 10'h000, 2'b00, 1'b1, 1'b1);
        rep(1, 4'b0101, 10'h000, 2'b10, 1'b0, 1'b1);
        cyc(1'b1, 10'h000, 4'b0101, 1'b0, 1'b1, 10'h000, 2'b10, 1'b0, 1'b1);
        puerta(4'b0101, 10'h000);
        rep(2, 4'b0101, 10'h000, 2'b00, 1'b0, 1'b0);

        // Car moving: door button ignored, hall call still latches
        cyc(1'b1, 10'h001, 4'b1101, 1'b0, 1'b1, 10'h000, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 10'h000, 4'b1101, 1'b0, 1'b1, 10'h001, 2'b00, 1'b0, 1'b0);
        cyc(1'b1, 10'h000, 4'b1101, 1'b0, 1'b0, 10'h001, 2'b00, 1'b0, 1'b0);
        rep(2, 4'b1101, 10'h001, 2'b00, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gestor_puertas.md
# gestor_puertas

Request register and door sequencer for the 4-floor lift controller. It latches hall and cabin button presses into the 10-bit request vector `s` that feeds the movement algorithm. When the car is stopped at a floor with a serviceable request, it runs the door open/dwell/close sequence and clears the served requests. While the door is not closed it holds `esperar` high, which freezes the movement algorithm.

## Interface
- `T_ABRIR`, default 50: door opening time, in clock cycles (1..65535).
- `T_ABIERTA`, default 200: dwell time with the door fully open, in cycles (1..65535).
- `T_CERRAR`, default 50: door closing time, in cycles (1..65535).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `botones`  in  10  button levels, already synchronous to `clk`; bit layout matches `s`.
- `estado`  in  4  car state from the movement algorithm:
  - [3] moving
  - [2] direction, 1 = up
  - [1:0] floor, 00 = floor 1 … 11 = floor 4
- `sensor_obstaculo`  in  1  door-path obstruction, level.
- `boton_abrir`  in  1  cabin door-open button, level.
- `s`  out  10  pending requests:
  - [0] floor-1 up, [1] floor-2 down, [2] floor-2 up, [3] floor-3 down, [4] floor-3 up, [5] floor-4 down
  - [6..9] cabin calls for floors 1..4
- `esperar`  out  1  hold for the movement algorithm; combinational.
- `motor_puerta`  out  2  01 = open, 10 = close, 00 = off; registered.
- `puerta_abierta`  out  1  door fully open; registered.

## Operation
- Let f = `estado[1:0]`.
- Served set S(f), per floor:
  - cabin bit 6+f.
  - Floor 1: hall bit 0. Floor 4: hall bit 5.
  - Floors 2/3: hall bit matching `estado[2]` (floor 2: 2 if up, 1 if down; floor 3: 4 if up, 3 if down).
- Trigger `abrir_pend` = FSM in CERRADA AND `estado[3]`=0 AND (any `s` bit in S(f) set OR `boton_abrir`).
- `esperar` = (FSM ≠ CERRADA) OR `abrir_pend`. It asserts in the same cycle the trigger appears, so the algorithm cannot start moving that cycle.
- Request latch:
  - Each cycle, `s[i]` is set if `botones[i]`=1.
  - On the CERRADA→ABRIENDO edge, the bits of S(f) clear; clear wins over set in that cycle.
  - While FSM ≠ CERRADA, presses of bits in S(f) are not latched. They count as a "same-floor press" (retrigger).
  - All other bits latch normally in every state.
- Door FSM, 16-bit down-counter `cnt`:
  - CERRADA: motor 00, `puerta_abierta`=0. On `abrir_pend`, go to ABRIENDO, load `cnt`=T_ABRIR-1, clear S(f).
  - ABRIENDO: motor 01. Decrement `cnt`. When `cnt`=0, go to ABIERTA and load T_ABIERTA-1.
  - ABIERTA: motor 00, `puerta_abierta`=1.
    - `sensor_obstaculo`, `boton_abrir` or a same-floor press reloads `cnt`=T_ABIERTA-1.
    - Otherwise, when `cnt`=0, go to CERRANDO and load T_CERRAR-1.
  - CERRANDO: motor 10.
    - `sensor_obstaculo`, `boton_abrir` or a same-floor press sends the FSM to ABRIENDO with `cnt`=T_ABRIR-1 (full reopen). This has priority over `cnt`=0.
    - Otherwise, when `cnt`=0, go to CERRADA.
- While `estado[3]`=1, `boton_abrir` is ignored; the FSM stays in CERRADA.
- A change of `estado` while FSM ≠ CERRADA is not expected. S(f) is re-evaluated from the current `estado`.

## Timing
- Reset values: `s`=0, FSM=CERRADA, `cnt`=0, `motor_puerta`=00, `puerta_abierta`=0. `esperar` then follows its combinational equation (0 with `s`=0 and `boton_abrir`=0).
- Reset mid-sequence: the door state is lost, outputs go to reset values at once, and pending requests are dropped.
- Button press → `s` bit visible: 1 cycle.
- Trigger cycle → ABRIENDO: next edge. ABRIENDO lasts exactly T_ABRIR cycles.
- Undisturbed ABIERTA lasts T_ABIERTA cycles; CERRANDO lasts T_CERRAR cycles.
- `esperar` high for 1 + T_ABRIR + T_ABIERTA + T_CERRAR cycles per undisturbed sequence.
- After returning to CERRADA: if a serviceable bit is still set (e.g. the opposite hall call is not in S(f)), the FSM does not re-trigger unless that bit is in the current S(f).

## Test plan
Use T_ABRIR=2, T_ABIERTA=4, T_CERRAR=2.
- Reset with `rst_n`=0 mid-ABIERTA → next sample shows `s`=0, motor 00, `puerta_abierta`=0, `esperar`=0.
- Car at floor 2 (`estado`=4'b0101), pulse `botones[7]` for 1 cycle → `s[7]`=1 next cycle, `esperar`=1 the same cycle, `s[7]` cleared on the following edge; motor 01 for 2, 00 with `puerta_abierta`=1 for 4, 10 for 2; `esperar` high for 9 cycles total.
- Car at floor 3 going up, `s[3]` and `s[4]` both set → only `s[4]` cleared, `s[3]` stays 1 after the sequence, no re-trigger.
- `sensor_obstaculo` held 3 cycles during ABIERTA → dwell extends; CERRANDO starts 4 cycles after sensor release.
- `boton_abrir` during the 2nd CERRANDO cycle → ABRIENDO (motor 01) next edge, full 2+4+2 repeats.
- `estado[3]`=1 with `boton_abrir`=1 and `botones[0]` pulse → FSM stays CERRADA, `esperar`=0, `s[0]`=1.
